// File: rtl/sfx_player.sv
// sfx_player: multi-effect tone sequencer for the 1-bit speaker pin.
// Each effect is a list of notes {loop, last, dur_ms, half_period} held in an
// external synchronous ROM. Trigger index 0 has the highest priority, and a
// higher-priority trigger preempts the effect that is playing.
// Optional build macro SFX_LOOP_EN: a note with last=1 and loop=1 restarts its
// effect at note 0, and a trigger on the playing effect's own index stops it.
module sfx_player #(
  parameter int CLK_HZ        = 100000000,
  parameter int NUM_SFX       = 4,
  parameter int NOTES_PER_SFX = 8,
  parameter int DIV_W         = 18,
  parameter int DUR_W         = 12,
  localparam int ADDR_W = (NUM_SFX * NOTES_PER_SFX > 1) ? $clog2(NUM_SFX * NOTES_PER_SFX) : 1,
  localparam int IDX_W  = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1,
  localparam int ROM_W  = DIV_W + DUR_W + 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_SFX-1:0] trig,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic              busy,
  output logic [IDX_W-1:0]  active_sfx,
  output logic              done,
  output logic              speaker
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NOTE_W   = (NOTES_PER_SFX > 1) ? $clog2(NOTES_PER_SFX) : 1;
  localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(NOTES_PER_SFX - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, PLAY} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   active_reg, active_next;
  logic [NOTE_W-1:0]  note_reg, note_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [DIV_W-1:0]   hp_reg, hp_next;
  logic [DIV_W-1:0]   tone_reg, tone_next;
  logic [DUR_W-1:0]   dur_reg, dur_next;
  logic [PRE_W-1:0]   pre_reg, pre_next;
  logic               last_reg, last_next;
  logic               speaker_reg, speaker_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic               trig_any;
  logic [IDX_W-1:0]   trig_idx;
  logic               preempt;
  logic               note_end;
  logic               cur_last;
  logic [DUR_W-1:0]   rom_dur;

`ifdef SFX_LOOP_EN
  logic               loop_reg, loop_next;
  logic               cur_loop;
  logic               self_stop;
`else
  logic               unused_loop_bit;
  assign unused_loop_bit = rom_data[ROM_W-1];
`endif

  assign rom_dur = rom_data[DIV_W +: DUR_W];

  // Flat note address of effect s, note n.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [IDX_W-1:0] s,
                                                   input logic [NOTE_W-1:0] n);
    int a;
    a = int'(s) * NOTES_PER_SFX + int'(n);
    return a[ADDR_W-1:0];
  endfunction

  // Priority encoder: lowest set trigger bit wins.
  always_comb begin
    trig_any = 1'b0;
    trig_idx = '0;
    for (int i = NUM_SFX - 1; i >= 0; i--) begin
      if (trig[i]) begin
        trig_any = 1'b1;
        trig_idx = IDX_W'(i);
      end
    end
  end

  assign preempt = (state_reg != IDLE) && trig_any && (trig_idx < active_reg);
`ifdef SFX_LOOP_EN
  assign self_stop = (state_reg != IDLE) && trig[active_reg];
`endif

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      active_reg  <= '0;
      note_reg    <= '0;
      addr_reg    <= '0;
      hp_reg      <= '0;
      tone_reg    <= '0;
      dur_reg     <= '0;
      pre_reg     <= '0;
      last_reg    <= 1'b0;
      speaker_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef SFX_LOOP_EN
      loop_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      active_reg  <= active_next;
      note_reg    <= note_next;
      addr_reg    <= addr_next;
      hp_reg      <= hp_next;
      tone_reg    <= tone_next;
      dur_reg     <= dur_next;
      pre_reg     <= pre_next;
      last_reg    <= last_next;
      speaker_reg <= speaker_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
`ifdef SFX_LOOP_EN
      loop_reg    <= loop_next;
`endif
    end
  end

  // Next-state logic: sequencing, tone/duration counting, end-of-note and preemption.
  always_comb begin
    state_next   = state_reg;
    active_next  = active_reg;
    note_next    = note_reg;
    addr_next    = addr_reg;
    hp_next      = hp_reg;
    tone_next    = tone_reg;
    dur_next     = dur_reg;
    pre_next     = pre_reg;
    last_next    = last_reg;
    speaker_next = speaker_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    note_end     = 1'b0;
    cur_last     = last_reg;
`ifdef SFX_LOOP_EN
    loop_next    = loop_reg;
    cur_loop     = loop_reg;
`endif

    case (state_reg)
      IDLE: begin
        // A trigger coinciding with the done pulse is dropped.
        if (trig_any && !done_reg) begin
          active_next = trig_idx;
          note_next   = '0;
          addr_next   = calc_addr(trig_idx, '0);
          busy_next   = 1'b1;
          state_next  = FETCH;
        end
      end
      FETCH: state_next = WAIT;
      WAIT:  state_next = LOAD;
      LOAD: begin
        hp_next   = rom_data[DIV_W-1:0];
        dur_next  = rom_dur;
        last_next = rom_data[DIV_W+DUR_W];
        cur_last  = rom_data[DIV_W+DUR_W];
`ifdef SFX_LOOP_EN
        loop_next = rom_data[ROM_W-1];
        cur_loop  = rom_data[ROM_W-1];
`endif
        tone_next = '0;
        pre_next  = '0;
        if (rom_dur == '0) note_end = 1'b1;
        else               state_next = PLAY;
      end
      PLAY: begin
        // Square wave: toggle when the tone counter wraps; half_period 0 is a rest.
        if (hp_reg == '0) begin
          tone_next    = '0;
          speaker_next = 1'b0;
        end else if (tone_reg == hp_reg - DIV_W'(1)) begin
          tone_next    = '0;
          speaker_next = ~speaker_reg;
        end else begin
          tone_next = tone_reg + DIV_W'(1);
        end
        // Millisecond prescaler drives the duration countdown.
        if (pre_reg == PRE_MAX) begin
          pre_next = '0;
          if (dur_reg == DUR_W'(1)) begin
            dur_next = '0;
            note_end = 1'b1;
          end else begin
            dur_next = dur_reg - DUR_W'(1);
          end
        end else begin
          pre_next = pre_reg + PRE_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (note_end) begin
      if (cur_last || note_reg == LAST_NOTE) begin
`ifdef SFX_LOOP_EN
        if (cur_last && cur_loop) begin
          note_next  = '0;
          addr_next  = calc_addr(active_reg, '0);
          state_next = FETCH;
        end else
`endif
        begin
          speaker_next = 1'b0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end
      end else begin
        note_next  = note_reg + NOTE_W'(1);
        addr_next  = calc_addr(active_reg, note_reg + NOTE_W'(1));
        state_next = FETCH;
      end
    end

`ifdef SFX_LOOP_EN
    // Retriggering the playing effect stops it like a natural end.
    if (self_stop) begin
      speaker_next = 1'b0;
      busy_next    = 1'b0;
      done_next    = 1'b1;
      state_next   = IDLE;
    end
`endif

    // Preemption overrides any end-of-note outcome and never pulses done.
    if (preempt) begin
      speaker_next = 1'b0;
      active_next  = trig_idx;
      note_next    = '0;
      addr_next    = calc_addr(trig_idx, '0);
      busy_next    = 1'b1;
      done_next    = 1'b0;
      state_next   = FETCH;
    end
  end

  assign rom_addr   = addr_reg;
  assign busy       = busy_reg;
  assign active_sfx = active_reg;
  assign done       = done_reg;
  assign speaker    = speaker_reg;

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player with CLK_HZ=10000 (1 ms = 10 clk).
// Edge numbers count rising edges after a trigger is driven; edge 1 is the
// edge that samples the trigger. Outputs are sampled 1 time unit after edges.
module tb_sfx_player;

  localparam int AW = 5;
  localparam int IW = 2;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    trig;
  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_data;
  logic          busy;
  logic [IW-1:0] active_sfx;
  logic          done;
  logic          speaker;

  logic [RW-1:0] rom [0:31];

  int tests_run    = 0;
  int tests_failed = 0;
  int ecount       = 0;
  int done_seen    = 0;
  int d0;

  sfx_player #(
    .CLK_HZ(10000), .NUM_SFX(4), .NOTES_PER_SFX(8), .DIV_W(18), .DUR_W(12)
  ) dut (
    .clk(clk), .rstn(rstn), .trig(trig), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .active_sfx(active_sfx), .done(done), .speaker(speaker)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Count cycles in which done is high.
  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic goto(input int n);
    while (ecount < n) step();
  endtask

  task automatic start(input logic [3:0] t);
    trig   = t;
    ecount = 0;
    step();
    trig   = '0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max) begin
      step();
      k++;
    end
    check(tag, done, 1);
  endtask

  function automatic logic [31:0] nw(input int lp, input int ls, input int dur, input int hp);
    logic [31:0] w;
    w = {lp[0], ls[0], dur[11:0], hp[17:0]};
    return w;
  endfunction

  initial begin
    rstn = 1'b0;
    trig = '0;
    for (int i = 0; i < 32; i++) rom[i] = nw(0, 0, 1, 2);
    rom[0]  = nw(0, 0, 1, 5);
    rom[1]  = nw(0, 0, 2, 0);
    rom[2]  = nw(0, 1, 1, 3);
    rom[8]  = nw(0, 1, 3, 2);
    rom[16] = nw(0, 1, 5, 4);
    rom[24] = nw(0, 0, 0, 2);

    // Reset state
    step(); step();
    check("rst.speaker", speaker, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.active", active_sfx, 0);
    check("rst.addr", rom_addr, 0);
    rstn = 1'b1;
    step(); step();

    // Single note: slot 8, hp=2, dur=3 ms
    d0 = done_seen;
    start(4'b0010);
    check("single.addr", rom_addr, 8);
    check("single.busy", busy, 1);
    check("single.active", active_sfx, 1);
    for (int n = 4; n <= 33; n++) begin
      goto(n);
      check("single.spk", speaker, ((n - 4) / 2) % 2);
    end
    check("single.done_early", done, 0);
    goto(34);
    check("single.done", done, 1);
    check("single.busy_end", busy, 0);
    check("single.spk_end", speaker, 0);
    check("single.active_end", active_sfx, 1);
    goto(36);
    check("single.done_count", done_seen - d0, 1);

    // Sequence with a rest: slots 0..2
    d0 = done_seen;
    start(4'b0001);
    check("seq.addr0", rom_addr, 0);
    goto(8);  check("seq.spk8", speaker, 0);
    goto(9);  check("seq.spk9", speaker, 1);
    goto(13); check("seq.spk13", speaker, 1);
    goto(14); check("seq.spk14", speaker, 0);
    check("seq.addr1", rom_addr, 1);
    goto(15); check("seq.gap_busy", busy, 1);
    goto(25); check("seq.rest", speaker, 0);
    goto(36); check("seq.addr_hold", rom_addr, 1);
    goto(37); check("seq.addr2", rom_addr, 2);
    goto(42); check("seq.spk42", speaker, 0);
    goto(43); check("seq.spk43", speaker, 1);
    goto(46); check("seq.spk46", speaker, 0);
    goto(49); check("seq.spk49", speaker, 1);
    goto(50); check("seq.done", done, 1);
    check("seq.busy_end", busy, 0);
    check("seq.spk_end", speaker, 0);
    goto(52); check("seq.done_count", done_seen - d0, 1);

    // Preemption: sfx 2 interrupted by sfx 0, then sfx 3 ignored
    d0 = done_seen;
    start(4'b0100);
    check("pre.addr16", rom_addr, 16);
    check("pre.active2", active_sfx, 2);
    goto(10); check("pre.spk_playing", speaker, 1);
    trig = 4'b0001;
    step();
    trig = '0;
    check("pre.active0", active_sfx, 0);
    check("pre.addr0", rom_addr, 0);
    check("pre.spk_cut", speaker, 0);
    check("pre.busy", busy, 1);
    check("pre.no_done", done_seen - d0, 0);
    goto(20);
    trig = 4'b1000;
    step();
    trig = '0;
    check("pre.ignore_active", active_sfx, 0);
    check("pre.ignore_addr", rom_addr, 0);
    wait_done("pre.done", 200);
    check("pre.done_active", active_sfx, 0);
    step(); step();
    check("pre.done_count", done_seen - d0, 1);

    // dur=0 skip at note 0, then all 8 slots of sfx 3 without last
    d0 = done_seen;
    start(4'b1000);
    check("skip.addr24", rom_addr, 24);
    goto(3);  check("skip.addr_hold", rom_addr, 24);
    goto(4);  check("skip.addr25", rom_addr, 25);
    goto(82); check("skip.addr31", rom_addr, 31);
    goto(94); check("skip.busy", busy, 1);
    check("skip.no_done_yet", done_seen - d0, 0);
    goto(95); check("skip.done", done, 1);
    check("skip.busy_end", busy, 0);
    check("skip.active", active_sfx, 3);
    step(); step();

    // Asynchronous reset between clock edges while playing
    start(4'b0010);
    goto(10);
    check("arst.spk_before", speaker, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst.speaker", speaker, 0);
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.addr", rom_addr, 0);
    check("arst.active", active_sfx, 0);
    step(); step();
    rstn = 1'b1;
    step();
    check("arst.idle_busy", busy, 0);
    d0 = done_seen;
    start(4'b0010);
    check("arst.restart_addr", rom_addr, 8);
    check("arst.restart_busy", busy, 1);
    wait_done("arst.replay_done", 60);
    step();
    check("arst.done_count", done_seen - d0, 1);

`ifdef SFX_LOOP_EN
    // Looping effect on slot 0, stopped by its own trigger
    rom[0] = nw(1, 1, 1, 4);
    step(); step();
    d0 = done_seen;
    start(4'b0001);
    check("loop.addr0", rom_addr, 0);
    goto(14); check("loop.busy_wrap", busy, 1);
    check("loop.addr_wrap", rom_addr, 0);
    goto(20); check("loop.spk20", speaker, 0);
    goto(21); check("loop.spk21", speaker, 1);
    goto(60); check("loop.busy60", busy, 1);
    check("loop.no_done", done_seen - d0, 0);
    trig = 4'b0001;
    step();
    trig = '0;
    check("loop.stop_done", done, 1);
    check("loop.stop_busy", busy, 0);
    check("loop.stop_spk", speaker, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
